// File: rtl/simd_alu_mc_pkg.sv
// Shared opcodes, FSM encoding and latency constants for the multi-cycle SIMD ALU.
package simd_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_EXP = 3'b100;
  localparam logic [2:0] OP_MIN = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b110;

  localparam int LAT_SINGLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_EXP);
  endfunction

endpackage

// File: rtl/simd_alu_mc_if.sv
// Request/response bundle between the register read stage and the SIMD ALU.
interface simd_alu_mc_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic [2:0]             op;
  logic                   sat;
  logic [LANES-1:0]       lane_mask;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] y;
  logic [LANES-1:0]       ovf;
  logic [LANES-1:0]       dz;
  logic                   busy;

  modport master (
    output in_valid, a, b, op, sat, lane_mask, out_ready,
    input  in_ready, out_valid, y, ovf, dz, busy
  );

  modport slave (
    input  in_valid, a, b, op, sat, lane_mask, out_ready,
    output in_ready, out_valid, y, ovf, dz, busy
  );
endinterface

// File: rtl/simd_alu_mc_lane_iter.sv
// One lane of the bit-serial datapath: restoring divider (acc=quotient, aux=remainder)
// or right-to-left square-and-multiply (acc=accumulator, aux=base, e=exponent).
module simd_lane_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             is_exp,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             dz
);

  logic [WIDTH-1:0]   acc, aux, e;
  logic               ovf_q;
  logic [2*WIDTH-1:0] p_acc, p_base;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_dif;
  logic               take;

  assign p_acc   = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, aux};
  assign p_base  = {{WIDTH{1'b0}}, aux} * {{WIDTH{1'b0}}, aux};
  assign rem_sh  = {aux, acc[WIDTH-1]};
  assign take    = rem_sh >= {1'b0, e};
  // true difference is below 2^WIDTH whenever it is taken, so the low bits suffice
  assign rem_dif = rem_sh[WIDTH-1:0] - e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      aux   <= '0;
      e     <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      acc   <= is_exp ? WIDTH'(1) : a_in;
      aux   <= is_exp ? a_in : '0;
      e     <= b_in;
      ovf_q <= 1'b0;
    end else if (step) begin
      if (is_exp) begin
        if (e[0]) acc <= p_acc[WIDTH-1:0];
        // squaring past the top set bit of the exponent is discarded, so it cannot flag
        if (|e[WIDTH-1:1]) aux <= p_base[WIDTH-1:0];
        ovf_q <= ovf_q | (e[0] & (|p_acc[2*WIDTH-1:WIDTH]))
                       | ((|e[WIDTH-1:1]) & (|p_base[2*WIDTH-1:WIDTH]));
        e <= e >> 1;
      end else begin
        aux <= take ? rem_dif : rem_sh[WIDTH-1:0];
        acc <= {acc[WIDTH-2:0], take};
      end
    end
  end

  assign result = acc;
  assign ovf    = ovf_q;
  assign dz     = (e == '0);

endmodule

// File: rtl/simd_alu_mc.sv
// Multi-cycle SIMD ALU: single-cycle ops plus bit-serial DIV/EXP, one op in flight.
//   state | meaning
//   IDLE  | ready for a new operation
//   ITER  | DIV/EXP lanes stepping, WIDTH iterations
//   DONE  | result registered on first cycle, held until out_ready
module simd_alu_mc
  import simd_alu_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int WIDTH  = 16,
  parameter int ITER_W = $clog2(WIDTH+1)
) (
  input logic          clk,
  input logic          rst_n,
  simd_alu_mc_if.slave bus
);

  localparam int VW       = LANES*WIDTH;
  localparam int LAT_ITER = WIDTH;

  state_t            state, state_nx;
  logic [ITER_W-1:0] cnt;
  logic [VW-1:0]     a_q, b_q, y_q, y_nx, it_res;
  logic [2:0]        op_q;
  logic              sat_q, out_valid_q;
  logic [LANES-1:0]  mask_q, ovf_q, ovf_nx, dz_q, dz_nx, it_ovf, it_dz;
  logic              accept, handshake, lane_exp, step;

  assign accept    = bus.in_valid && (state == ST_IDLE);
  assign handshake = out_valid_q && bus.out_ready;
  assign step      = (state == ST_ITER);
  assign lane_exp  = (state == ST_IDLE) ? (bus.op == OP_EXP) : (op_q == OP_EXP);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = is_iter_op(bus.op) ? ST_ITER : ST_DONE;
      ST_ITER: if (cnt == ITER_W'(1)) state_nx = ST_DONE;
      ST_DONE: if (handshake) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      sat_q       <= 1'b0;
      mask_q      <= '0;
      y_q         <= '0;
      ovf_q       <= '0;
      dz_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q    <= bus.a;
        b_q    <= bus.b;
        op_q   <= bus.op;
        sat_q  <= bus.sat;
        mask_q <= bus.lane_mask;
        cnt    <= is_iter_op(bus.op) ? ITER_W'(LAT_ITER) : ITER_W'(LAT_SINGLE - 1);
      end else if (state == ST_ITER) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ST_DONE && !out_valid_q) begin
        out_valid_q <= 1'b1;
        y_q         <= y_nx;
        ovf_q       <= ovf_nx;
        dz_q        <= dz_nx;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0]   al, bl, r;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic               o, d;

    assign al   = a_q[i*WIDTH +: WIDTH];
    assign bl   = b_q[i*WIDTH +: WIDTH];
    assign sum  = {1'b0, al} + {1'b0, bl};
    assign prod = {{WIDTH{1'b0}}, al} * {{WIDTH{1'b0}}, bl};

    simd_lane_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept),
      .step   (step),
      .is_exp (lane_exp),
      .a_in   (bus.a[i*WIDTH +: WIDTH]),
      .b_in   (bus.b[i*WIDTH +: WIDTH]),
      .result (it_res[i*WIDTH +: WIDTH]),
      .ovf    (it_ovf[i]),
      .dz     (it_dz[i])
    );

    always_comb begin
      r = sum[WIDTH-1:0];
      o = sum[WIDTH];
      d = 1'b0;
      case (op_q)
        OP_SUB: begin r = al - bl; o = (al < bl); end
        OP_MUL: begin r = prod[WIDTH-1:0]; o = |prod[2*WIDTH-1:WIDTH]; end
        OP_DIV: begin d = it_dz[i]; r = d ? '1 : it_res[i*WIDTH +: WIDTH]; o = 1'b0; end
        OP_EXP: begin r = it_res[i*WIDTH +: WIDTH]; o = it_ovf[i]; end
        OP_MIN: begin r = (al < bl) ? al : bl; o = 1'b0; end
        OP_MAX: begin r = (al > bl) ? al : bl; o = 1'b0; end
        default: ;
      endcase
      if (sat_q && o) r = (op_q == OP_SUB) ? '0 : '1;
      if (!mask_q[i]) begin
        r = al;
        o = 1'b0;
        d = 1'b0;
      end
    end

    assign y_nx[i*WIDTH +: WIDTH] = r;
    assign ovf_nx[i]              = o;
    assign dz_nx[i]               = d;
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_simd_alu_mc.sv
// Self-checking bench for simd_alu_mc: directed plan cases plus random ops vs a lane-level model.
module tb_simd_alu_mc;
  import simd_alu_pkg::*;

  localparam int L = 8;
  localparam int W = 16;
  localparam int VW = L*W;
  localparam longint MAXV = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  simd_alu_mc_if #(.LANES(L), .WIDTH(W)) bus();
  simd_alu_mc #(.LANES(L), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Arithmetic meaning of each op on plain integers; EXP uses repeated multiplication.
  function automatic void model(input logic [VW-1:0] av, input logic [VW-1:0] bv,
                                input logic [2:0] opv, input logic sv, input logic [L-1:0] mv,
                                output logic [VW-1:0] yv, output logic [L-1:0] ov,
                                output logic [L-1:0] dv);
    longint x, z, r, t;
    bit o, d;
    for (int i = 0; i < L; i++) begin
      x = longint'(av[i*W +: W]);
      z = longint'(bv[i*W +: W]);
      o = 0; d = 0;
      case (opv)
        OP_SUB: begin r = x - z; o = (x < z); end
        OP_MUL: begin r = x * z; o = (r > MAXV); end
        OP_DIV: if (z == 0) begin d = 1; r = MAXV; end else r = x / z;
        OP_EXP: begin
          r = 1; t = 1;
          for (longint k = 0; k < z; k++) begin
            r = (r * x) % 65536;
            if (!o) begin t = t * x; if (t > MAXV) o = 1; end
          end
        end
        OP_MIN: r = (x < z) ? x : z;
        OP_MAX: r = (x > z) ? x : z;
        default: begin r = x + z; o = (r > MAXV); end
      endcase
      if (sv && o) r = (opv == OP_SUB) ? 0 : MAXV;
      if (!mv[i]) begin r = x; o = 0; d = 0; end
      yv[i*W +: W] = 16'(r & MAXV);
      ov[i] = o;
      dv[i] = d;
    end
  endfunction

  // Issue one op and wait for out_valid; lat = edges after the accept edge, -1 on timeout.
  task automatic do_op(input logic [VW-1:0] av, input logic [VW-1:0] bv, input logic [2:0] opv,
                       input logic sv, input logic [L-1:0] mv, output int lat);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.op = opv; bus.sat = sv; bus.lane_mask = mv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 100) lat = -1;
  endtask

  task automatic drain();
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.y !== '0 || bus.ovf !== '0 || bus.dz !== '0) begin
      n_fail++;
      $display("FAIL reset_data: y=%h ovf=%h dz=%h required all zero", bus.y, bus.ovf, bus.dz);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add_wrap_sat();
    logic [VW-1:0] av, bv, ye;
    int lat;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < L; i++) begin
        av[i*W +: W] = 16'(i); bv[i*W +: W] = 16'(i); ye[i*W +: W] = 16'(2*i);
      end
      av[15:0] = 16'hFFF0; bv[15:0] = 16'h0020;
      ye[15:0] = (s == 1) ? 16'hFFFF : 16'h0010;
      do_op(av, bv, OP_ADD, s[0], 8'hFF, lat);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL add_latency sat=%0d: got %0d required 1", s, lat); end
      n_checks++;
      if (bus.y !== ye || bus.ovf !== 8'h01 || bus.dz !== 8'h00) begin
        n_fail++;
        $display("FAIL add_result sat=%0d: y=%h ovf=%h dz=%h required y=%h ovf=01 dz=00",
                 s, bus.y, bus.ovf, bus.dz, ye);
      end
      drain();
    end
  endtask

  task automatic test_div();
    logic [VW-1:0] av, bv, ye;
    int lat;
    int q [L] = '{14, 14, 14, 65535, 14, 15, 15, 15};
    for (int i = 0; i < L; i++) begin
      av[i*W +: W] = 16'(100 + i);
      bv[i*W +: W] = (i == 3) ? 16'd0 : 16'd7;
      ye[i*W +: W] = 16'(q[i]);
    end
    do_op(av, bv, OP_DIV, 1'b1, 8'hFF, lat);
    n_checks++;
    if (lat !== 17) begin n_fail++; $display("FAIL div_latency: got %0d required 17", lat); end
    n_checks++;
    if (bus.y !== ye || bus.dz !== 8'h08 || bus.ovf !== 8'h00) begin
      n_fail++;
      $display("FAIL div_result: y=%h dz=%h ovf=%h required y=%h dz=08 ovf=00",
               bus.y, bus.dz, bus.ovf, ye);
    end
    drain();
  endtask

  task automatic test_exp();
    logic [VW-1:0] av, bv, ye;
    int lat;
    int ea [4] = '{3, 2, 0, 7};
    int eb [4] = '{5, 16, 0, 1};
    int er [4] = '{243, 65535, 1, 7};
    for (int i = 0; i < L; i++) begin
      av[i*W +: W] = (i < 4) ? 16'(ea[i]) : 16'(i);
      bv[i*W +: W] = (i < 4) ? 16'(eb[i]) : 16'd3;
      ye[i*W +: W] = (i < 4) ? 16'(er[i]) : 16'(i*i*i);
    end
    do_op(av, bv, OP_EXP, 1'b1, 8'hFF, lat);
    n_checks++;
    if (lat !== 17) begin n_fail++; $display("FAIL exp_latency: got %0d required 17", lat); end
    n_checks++;
    if (bus.y !== ye || bus.ovf !== 8'h02 || bus.dz !== 8'h00) begin
      n_fail++;
      $display("FAIL exp_result: y=%h ovf=%h dz=%h required y=%h ovf=02 dz=00",
               bus.y, bus.ovf, bus.dz, ye);
    end
    drain();
  endtask

  task automatic test_mask_minmax();
    logic [VW-1:0] av, bv, ye;
    int lat;
    for (int i = 0; i < L; i++) begin
      av[i*W +: W] = 16'd10; bv[i*W +: W] = 16'd20;
      ye[i*W +: W] = (i < 4) ? 16'd20 : 16'd10;
    end
    do_op(av, bv, OP_MAX, 1'b0, 8'h0F, lat);
    n_checks++;
    if (lat !== 1 || bus.y !== ye || bus.ovf !== 8'h00 || bus.dz !== 8'h00) begin
      n_fail++;
      $display("FAIL mask_max: lat=%0d y=%h ovf=%h dz=%h required lat=1 y=%h flags 0",
               lat, bus.y, bus.ovf, bus.dz, ye);
    end
    drain();
  endtask

  task automatic test_random();
    logic [VW-1:0] av, bv, ye;
    logic [L-1:0] oe, de, mv;
    logic [2:0] opv;
    logic sv;
    int lat, le;
    for (int n = 0; n < 40; n++) begin
      opv = 3'($urandom_range(0, 7));
      sv = 1'($urandom_range(0, 1));
      mv = 8'($urandom);
      for (int i = 0; i < L; i++) begin
        av[i*W +: W] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
        bv[i*W +: W] = 16'($urandom);
        if (opv == OP_EXP) bv[i*W +: W] = 16'($urandom_range(0, 20));
        if (opv == OP_DIV && $urandom_range(0, 3) == 0) bv[i*W +: W] = 16'd0;
      end
      model(av, bv, opv, sv, mv, ye, oe, de);
      le = (opv == OP_DIV || opv == OP_EXP) ? 17 : 1;
      do_op(av, bv, opv, sv, mv, lat);
      n_checks++;
      if (lat !== le || bus.y !== ye || bus.ovf !== oe || bus.dz !== de) begin
        n_fail++;
        $display("FAIL random op=%0d sat=%b mask=%h: lat=%0d y=%h ovf=%h dz=%h required lat=%0d y=%h ovf=%h dz=%h",
                 opv, sv, mv, lat, bus.y, bus.ovf, bus.dz, le, ye, oe, de);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] av, bv, ye;
    logic [L-1:0] oe, de;
    int lat, bad;
    for (int i = 0; i < L; i++) begin
      av[i*W +: W] = 16'd5; bv[i*W +: W] = 16'(2*i);
    end
    model(av, bv, OP_SUB, 1'b0, 8'hFF, ye, oe, de);
    do_op(av, bv, OP_SUB, 1'b0, 8'hFF, lat);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.a = ~av; bus.b = av; bus.op = OP_ADD; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.y !== ye || bus.ovf !== oe) bad++;
    end
    n_checks++;
    if (lat !== 1 || bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: lat=%0d unstable_cycles=%0d y=%h ovf=%h required lat=1 0 y=%h ovf=%h",
               lat, bad, bus.y, bus.ovf, ye, oe);
    end
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    @(negedge clk);
    bus.a = {L{16'd3}}; bus.b = {L{16'd4}}; bus.op = OP_ADD; bus.sat = 1'b0; bus.lane_mask = 8'hFF;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.in_ready === 1'b1) accepts++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_checks++;
    if (accepts != 4) begin
      n_fail++;
      $display("FAIL throughput: accepts in 12 cycles=%0d required 4", accepts);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [VW-1:0] av, bv, ye;
    logic [L-1:0] oe, de;
    int lat, seen;
    @(negedge clk);
    bus.a = {L{16'd1000}}; bus.b = {L{16'd9}}; bus.op = OP_DIV; bus.sat = 1'b0;
    bus.lane_mask = 8'hFF; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.y !== '0 || bus.ovf !== '0 || bus.dz !== '0 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_div: y=%h ovf=%h dz=%h out_valid=%b busy=%b in_ready=%b required zeros, in_ready=1",
               bus.y, bus.ovf, bus.dz, bus.out_valid, bus.busy, bus.in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_discard: out_valid cycles=%0d required 0", seen); end
    for (int i = 0; i < L; i++) begin
      av[i*W +: W] = 16'($urandom); bv[i*W +: W] = 16'($urandom);
    end
    model(av, bv, OP_ADD, 1'b1, 8'hFF, ye, oe, de);
    do_op(av, bv, OP_ADD, 1'b1, 8'hFF, lat);
    n_checks++;
    if (lat !== 1 || bus.y !== ye || bus.ovf !== oe || bus.dz !== de) begin
      n_fail++;
      $display("FAIL add_after_reset: lat=%0d y=%h ovf=%h required lat=1 y=%h ovf=%h",
               lat, bus.y, bus.ovf, ye, oe);
    end
    drain();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    bus.op = OP_ADD; bus.sat = 1'b0; bus.lane_mask = '0;
    test_reset();
    test_add_wrap_sat();
    test_div();
    test_exp();
    test_mask_minmax();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
